// File: rtl/btree_hit_sequencer.sv
// btree_hit_sequencer: time-multiplexed topmost-hit resolver.
// Reduces a RECT_COUNT-bit hit vector CHUNK flags per cycle through one shared
// priority tree and reports the highest set index plus an any-hit flag.
// Optional feature macro: BTREE_SEQ_EARLY_EXIT_EN (scan top chunk down, stop at
// the first chunk with a hit). Default build scans every chunk ascending.

`ifndef RECT_COUNT
`define RECT_COUNT 64
`endif
`ifndef RECT_COUNT_WIDTH
`define RECT_COUNT_WIDTH $clog2(`RECT_COUNT)
`endif

module btree_hit_sequencer #(
  parameter int unsigned RECT_COUNT       = `RECT_COUNT,
  parameter int unsigned RECT_COUNT_WIDTH = `RECT_COUNT_WIDTH,
  parameter int unsigned CHUNK            = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [RECT_COUNT-1:0]       flags_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        hit_out,
  output logic [RECT_COUNT_WIDTH-1:0] index_out
);

  localparam int unsigned NCHUNK = RECT_COUNT / CHUNK;
  localparam int unsigned CW     = $clog2(CHUNK);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic [RECT_COUNT-1:0]       r_flags;
  logic [KW-1:0]               r_k;
  logic                        r_hit;
  logic [RECT_COUNT_WIDTH-1:0] r_idx;
  logic                        r_in_ready;
  logic                        r_out_valid;

  logic [KW+CW-1:0]            w_base;
  logic [CHUNK-1:0]            w_chunk;
  logic                        w_any;
  logic [CW-1:0]               w_bit;
  logic [KW+CW-1:0]            w_cat;

  // Chunk base is {k, CW zeros}: the chunk offset needs no adder.
  assign w_base  = {r_k, {CW{1'b0}}};
  assign w_chunk = r_flags[w_base +: CHUNK];
  assign w_cat   = {r_k, w_bit};

  // Shared CHUNK-wide priority tree: highest set bit in the current chunk wins.
  always_comb begin
    w_any = 1'b0;
    w_bit = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (w_chunk[i]) begin
        w_any = 1'b1;
        w_bit = CW'(i);
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_flags     <= '0;
      r_k         <= '0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_flags    <= flags_in;
            r_hit      <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
`ifdef BTREE_SEQ_EARLY_EXIT_EN
            r_k        <= K_LAST;
`else
            r_k        <= '0;
`endif
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_any) begin
            r_hit <= 1'b1;
            r_idx <= RECT_COUNT_WIDTH'(w_cat);
          end
`ifdef BTREE_SEQ_EARLY_EXIT_EN
          // Descending scan: the first hit chunk already holds the topmost flag.
          if (w_any || (r_k == '0)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k - K_ONE;
          end
`else
          // Ascending scan: later hit chunks overwrite the winner.
          if (r_k == K_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k + K_ONE;
          end
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign hit_out   = r_hit;
  assign index_out = r_idx;

endmodule

// File: tb/tb_btree_hit_sequencer.sv
// Scoreboard bench for btree_hit_sequencer (RECT_COUNT=64, CHUNK=8).
// Stimulus pushes hand-computed results; a negedge monitor pops and compares.
module tb_btree_hit_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] flags_in;
  logic        out_valid;
  logic        out_ready;
  logic        hit_out;
  logic [5:0]  index_out;

  btree_hit_sequencer #(
    .RECT_COUNT      (64),
    .RECT_COUNT_WIDTH(6),
    .CHUNK           (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flags_in (flags_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .hit_out  (hit_out),
    .index_out(index_out)
  );

  typedef struct {
    logic        hit;
    int unsigned idx;
    int unsigned lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t cur;
  bit   in_res;
  int   cyc;
  int   total;
  int   bad;

`ifdef BTREE_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: record accept cycles, pop expected result on first out_valid,
  // and hold-check the result for every cycle it stays valid.
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      in_res = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid) begin
        if (!in_res) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            cur    = exp_q.pop_front();
            in_res = 1'b1;
            if (acc_q.size() == 0) check("accept_seen", 0, 1);
            else check("latency", cyc - acc_q.pop_front(), int'(cur.lat));
            check("hit_out", int'(hit_out), int'(cur.hit));
            check("index_out", int'(index_out), int'(cur.idx));
          end
        end else begin
          check("hold_hit", int'(hit_out), int'(cur.hit));
          check("hold_index", int'(index_out), int'(cur.idx));
        end
        check("in_ready_low_in_done", int'(in_ready), 0);
        if (out_ready) in_res = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) timeout_fail(name);
  endtask

  // Present one vector for exactly one accept cycle, then scramble flags_in.
  task automatic issue(input logic [63:0] f, input bit push, input bit h,
                       input int unsigned idx, input int unsigned lat_def,
                       input int unsigned lat_early);
    exp_t e;
    wait_ready("wait_in_ready");
    if (push) begin
      e.hit = h;
      e.idx = idx;
      e.lat = EARLY ? lat_early : lat_def;
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    flags_in = f;
    step();
    in_valid = 1'b0;
    flags_in = ~f;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || out_valid) timeout_fail(name);
  endtask

  initial begin
    int n;
    total     = 0;
    bad       = 0;
    in_res    = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flags_in  = '0;

    // Test 1: reset values
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_hit", int'(hit_out), 0);
    check("rst_index", int'(index_out), 0);
    step();
    out_ready = 1'b1;

    // Test 2: bits 3, 17, 42
    issue(64'h0000_0400_0002_0008, 1'b1, 1'b1, 42, 9, 4);
    drain("t2_drain");
    // Test 3: all zero
    issue(64'h0, 1'b1, 1'b0, 0, 9, 9);
    drain("t3_drain");
    // Test 4: all ones
    issue({64{1'b1}}, 1'b1, 1'b1, 63, 9, 2);
    drain("t4_drain");
    // Extra: bits 8 and 63; bits 8 and 15 in one chunk
    issue(64'h8000_0000_0000_0100, 1'b1, 1'b1, 63, 9, 2);
    drain("t4b_drain");
    issue(64'h0000_0000_0000_8100, 1'b1, 1'b1, 15, 9, 8);
    drain("t4c_drain");

    // Test 5: back-pressure in DONE with a new vector waiting
    out_ready = 1'b0;
    issue(64'h0000_0000_0000_0080, 1'b1, 1'b1, 7, 9, 9);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) timeout_fail("t5_wait_out_valid");
    begin
      exp_t e;
      e.hit = 1'b1;
      e.idx = 40;
      e.lat = EARLY ? 4 : 9;
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    flags_in = 64'h0000_0100_0000_0000;
    repeat (5) step();
    check("t5_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    check("t5_ready_after_handshake", int'(in_ready), 1);
    check("t5_valid_dropped", int'(out_valid), 0);
    step();
    in_valid = 1'b0;
    flags_in = '0;
    check("t5_new_vector_taken", int'(in_ready), 0);
    drain("t5_drain");

    // Test 6: reset mid-SCAN aborts
    issue(64'h0, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_idle_ready", int'(in_ready), 1);
    check("t6_no_valid", int'(out_valid), 0);
    repeat (12) begin
      step();
      check("t6_never_valid", int'(out_valid), 0);
    end
    issue(64'h1, 1'b1, 1'b1, 0, 9, 9);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
